// File: rtl/fifo_tx_feeder.sv
// Read-domain feeder: pops one byte from the async FIFO and hands it to the UART
// transmitter, holding it until TX has accepted and finished the frame.
module fifo_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic [CNT_WIDTH-1:0]  tx_count,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  rinc_q, rinc_d;
  logic [CNT_WIDTH-1:0]  tx_count_q, tx_count_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  err_set;

  // Handshake: tx_valid rises with tx_data and stays up until TX raises tx_busy
  // (acceptance) or the timer expires; busy already high before the pop never
  // counts as acceptance because IDLE refuses to pop while it is high.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rinc_d     = 1'b0;
    tx_count_d = tx_count_q;
    timer_d    = timer_q;
    err_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !rempty && !tx_busy) begin
          tx_data_d  = rdata;
          rinc_d     = 1'b1;
          tx_valid_d = 1'b1;
          timer_d    = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tx_busy) begin
          tx_valid_d = 1'b0;
          tx_count_d = tx_count_q + CNT_WIDTH'(1);
          state_d    = ST_BUSY;
        end else if (timer_q == TIMER_LAST) begin
          tx_valid_d = 1'b0;
          err_set    = 1'b1;
          state_d    = ST_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_BUSY: begin
        if (!tx_busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        // One settle cycle so rempty reflects the completed pop.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    timeout_err_d = err_set | (timeout_err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      rinc_q        <= 1'b0;
      tx_count_q    <= '0;
      timeout_err_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      rinc_q        <= rinc_d;
      tx_count_q    <= tx_count_d;
      timeout_err_q <= timeout_err_d;
      timer_q       <= timer_d;
    end
  end

  assign rinc        = rinc_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_count    = tx_count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fifo_tx_feeder.sv
// Bench for fifo_tx_feeder: FIFO and UART TX models, a transaction-level
// reference model compared every cycle, directed cases, then random traffic.
module tb_fifo_tx_feeder;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          rempty = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          rinc;
  logic          tx_busy;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic [CW-1:0] tx_count;
  logic          timeout_err;
  logic          err_clr = 1'b0;

  logic tx_busy_r = 1'b0;
  logic tx_force = 1'b0;
  assign tx_busy = tx_busy_r | tx_force;

  // clock / reset
  always #5 clk = ~clk;

  fifo_tx_feeder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .tx_busy(tx_busy), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_count(tx_count), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO contents seen by the DUT, and the scoreboard of bytes expected at TX
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int tx_lat = 0, tx_len = 1, tx_age = 0, tx_hold = 0;
  int n_rinc = 0, cyc = 0, last_rinc_cyc = 0, rinc_gap = 0;
  int valid_len = 0, last_valid_len = 0;

  always @(negedge clk) begin
    cyc++;
    if (rinc === 1'b1) begin
      n_rinc++;
      rinc_gap      = cyc - last_rinc_cyc;
      last_rinc_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: rinc with nothing queued at %0t", $time);
      end else begin
        chk("sb_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (tx_valid === 1'b1) valid_len++;
    else if (valid_len != 0) begin
      last_valid_len = valid_len;
      valid_len      = 0;
    end
    // UART TX model: accepts after tx_lat cycles of valid, busy for tx_len cycles
    if (tx_busy_r) begin
      if (tx_hold > 0) tx_hold--;
      if (tx_hold == 0) tx_busy_r = 1'b0;
    end else if (tx_valid === 1'b1) begin
      if (tx_age >= tx_lat) begin
        tx_busy_r = 1'b1;
        tx_hold   = tx_len;
        tx_age    = 0;
      end else tx_age++;
    end else tx_age = 0;
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? DW'($urandom) : fifo_q[0];
  end

  // reference model: byte-transaction view, updated on each rising edge
  logic [DW-1:0] m_data;
  logic m_valid, m_rinc, m_err, m_inflight, m_accepted, m_settle, m_set;
  int   m_age, m_sent;
  logic check_on = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_data = '0; m_valid = 0; m_rinc = 0; m_err = 0;
      m_inflight = 0; m_accepted = 0; m_settle = 0; m_age = 0; m_sent = 0;
      check_on = 1'b1;
    end else begin
      m_rinc = 0;
      m_set  = 0;
      if (m_settle) m_settle = 0;
      else if (!m_inflight) begin
        if (enable && !rempty && !tx_busy) begin
          m_data = rdata; m_valid = 1; m_rinc = 1;
          m_inflight = 1; m_accepted = 0; m_age = 0;
        end
      end else if (!m_accepted) begin
        if (tx_busy) begin
          m_valid = 0; m_accepted = 1; m_sent++;
        end else if (m_age == TO - 1) begin
          m_valid = 0; m_set = 1; m_inflight = 0; m_settle = 1;
        end else m_age++;
      end else if (!tx_busy) begin
        m_inflight = 0; m_settle = 1;
      end
      m_err = m_set ? 1'b1 : (err_clr ? 1'b0 : m_err);
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_valid});
      chk("rinc", {31'd0, rinc}, {31'd0, m_rinc});
      chk("tx_data", {24'd0, tx_data}, {24'd0, m_data});
      chk("tx_count", {28'd0, tx_count}, m_sent % (1 << CW));
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
    end
  end

  // driver tasks
  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_rinc();
    int seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      @(negedge clk);
      if (rinc === 1'b1) seen = 1;
    end
    chk("wait_rinc", seen, 1);
  endtask

  task automatic drain();
    int quiet = 0;
    for (int i = 0; i < 600 && quiet < 6; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && tx_valid === 1'b0 && tx_busy === 1'b0) quiet++;
      else quiet = 0;
    end
    chk("drain", quiet, 6);
  endtask

  int base;

  initial begin
    // reset with a byte waiting and enable high
    enable = 1'b1; tx_lat = 2; tx_len = 10;
    push(8'hA5);
    repeat (3) @(negedge clk);
    chk("rst_no_rinc", n_rinc, 0);
    chk("rst_valid", {31'd0, tx_valid}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_rinc", {31'd0, rinc}, 1);
    chk("first_data", {24'd0, tx_data}, 32'hA5);
    drain();
    chk("single_vlen", last_valid_len, 3);
    chk("single_rinc", n_rinc, 1);
    chk("single_cnt", {28'd0, tx_count}, 1);

    // burst of four, TX responds at once with a one-cycle frame
    tx_lat = 0; tx_len = 1; base = n_rinc;
    for (int b = 1; b <= 4; b++) push(DW'(b));
    drain();
    chk("burst_rinc", n_rinc - base, 4);
    chk("burst_cnt", {28'd0, tx_count}, 5);
    chk("burst_gap", rinc_gap, 4);

    // timeout with clear landing on the set edge
    tx_lat = 1000;
    push(8'h3C);
    wait_rinc();
    repeat (15) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_set", {31'd0, timeout_err}, 1);
    chk("to_valid", {31'd0, tx_valid}, 0);
    @(negedge clk);
    chk("to_vlen", last_valid_len, 16);
    chk("to_cnt", {28'd0, tx_count}, 5);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", {31'd0, timeout_err}, 0);
    tx_lat = 0;
    drain();

    // enable dropped while the first of two bytes is in BUSY
    tx_len = 8; base = n_rinc;
    push(8'h11); push(8'h22);
    wait_rinc();
    @(negedge clk);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("en_rinc", n_rinc - base, 1);
    chk("en_cnt", {28'd0, tx_count}, 6);
    chk("en_fifo", fifo_q.size(), 1);
    enable = 1'b1;
    drain();
    chk("en_cnt2", {28'd0, tx_count}, 7);

    // busy already high in IDLE blocks the pop
    tx_force = 1'b1; base = n_rinc;
    push(8'h5A);
    repeat (10) @(negedge clk);
    chk("blk_rinc", n_rinc - base, 0);
    tx_force = 1'b0;
    drain();
    chk("blk_cnt", {28'd0, tx_count}, 8);

    // reset pulsed in BUSY: outputs clear, no extra pop, lost byte not counted
    tx_len = 10; base = n_rinc;
    push(8'h77); push(8'h88);
    wait_rinc();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rb_valid", {31'd0, tx_valid}, 0);
    chk("rb_data", {24'd0, tx_data}, 0);
    chk("rb_cnt", {28'd0, tx_count}, 0);
    chk("rb_rinc", {31'd0, rinc}, 0);
    @(negedge clk);
    chk("rb_no_rinc", n_rinc - base, 1);
    rst_n = 1'b1;
    drain();
    chk("rb_cnt2", {28'd0, tx_count}, 1);

    // counter wrap: 17 bytes since reset
    tx_len = 1; base = n_rinc;
    for (int i = 0; i < 16; i++) push(DW'($urandom));
    drain();
    chk("wrap_rinc", n_rinc - base, 16);
    chk("wrap_cnt", {28'd0, tx_count}, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) push(DW'($urandom));
      enable  = ($urandom_range(0, 7) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) begin
        tx_lat = $urandom_range(0, 18);
        tx_len = $urandom_range(1, 5);
      end
      tx_force = ($urandom_range(0, 39) == 0);
      rst_n    = ($urandom_range(0, 599) != 0);
    end
    rst_n = 1'b1; tx_force = 1'b0; err_clr = 1'b0; enable = 1'b1; tx_lat = 0;
    drain();
    chk("final_sb_empty", exp_q.size(), 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
